// File: rtl/adder_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : adder_accumulator
// Purpose  : Collects a burst of 9-bit adder results ({carry, sum[7:0]}) into
//            an ACC_W-bit running total and presents the total, together with
//            a sticky overflow flag, over a valid/ready handshake.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start, len        - begin a burst of len beats (IDLE only)
//            in_valid, in_sum, - beat input handshake
//            in_ready
//            out_valid,        - result handshake
//            out_ready
//            out_data          - accumulated total mod 2^ACC_W
//            out_overflow      - any addition in the burst carried out
//            busy              - block is not idle
// Revision : 1.0 - initial release
// ============================================================================
module adder_accumulator #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [8:0]       in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_overflow,
    output logic             busy
);

    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_ACCUM = 2'd1;
    localparam logic [1:0]       c_ST_DONE  = 2'd2;
    localparam logic [LEN_W-1:0] c_LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] c_LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic             r_overflow;
    logic [LEN_W-1:0] r_remaining;

    logic             w_beat;
    logic             w_last_beat;
    logic [ACC_W:0]   w_sum_ext;

    // A beat only transfers while collecting; in_ready is decoded from state.
    assign w_beat      = in_valid && (r_state == c_ST_ACCUM);
    assign w_last_beat = w_beat && (r_remaining == c_LEN_ONE);

    // One extra bit on the adder captures the carry out of the accumulator.
    assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W-8){1'b0}}, in_sum};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    // An empty burst goes straight to presenting a zero total.
                    if (len == c_LEN_ZERO) begin
                        w_state_next = c_ST_DONE;
                    end else begin
                        w_state_next = c_ST_ACCUM;
                    end
                end
            end
            c_ST_ACCUM: begin
                if (w_last_beat) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, sticky overflow, beat countdown.
    // The total and flag are only cleared by start or rst, so they keep
    // showing the last result after the output handshake completes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_overflow  <= 1'b0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_acc       <= '0;
                        r_overflow  <= 1'b0;
                        r_remaining <= len;
                    end
                end
                c_ST_ACCUM: begin
                    if (w_beat) begin
                        r_acc       <= w_sum_ext[ACC_W-1:0];
                        r_overflow  <= r_overflow | w_sum_ext[ACC_W];
                        r_remaining <= r_remaining - c_LEN_ONE;
                    end
                end
                default: begin
                    r_acc       <= r_acc;
                    r_overflow  <= r_overflow;
                    r_remaining <= r_remaining;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: state decodes and register copies only, so out_ready has
    // no combinational path to any output.
    // ------------------------------------------------------------------
    assign in_ready     = (r_state == c_ST_ACCUM);
    assign out_valid    = (r_state == c_ST_DONE);
    assign busy         = (r_state != c_ST_IDLE);
    assign out_data     = r_acc;
    assign out_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_adder_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_accumulator
// Purpose  : Self-checking bench for adder_accumulator. Two instances
//            (ACC_W=16 and ACC_W=10) share one directed stimulus stream; a
//            burst-level model keeps the unbounded running total and derives
//            each instance's expected outputs from it every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_accumulator;

    localparam int LEN_W = 4;
    localparam int WA    = 16;
    localparam int WB    = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [8:0]       in_sum;
    logic             out_ready;

    logic             a_in_ready, a_out_valid, a_out_overflow, a_busy;
    logic [WA-1:0]    a_out_data;
    logic             b_in_ready, b_out_valid, b_out_overflow, b_busy;
    logic [WB-1:0]    b_out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_accumulator #(.ACC_W(WA), .LEN_W(LEN_W)) dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_sum(in_sum), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_overflow(a_out_overflow), .busy(a_busy)
    );

    adder_accumulator #(.ACC_W(WB), .LEN_W(LEN_W)) dut_b (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_sum(in_sum), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_overflow(b_out_overflow), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Burst-level model: mode 0 waiting for start, 1 collecting beats,
    // 2 holding a result. The total is kept unbounded; each width's output
    // is that total mod 2^W and overflow is "total reached 2^W".
    // ------------------------------------------------------------------
    int    m_mode  = 0;
    int    m_left  = 0;
    longint m_total = 0;
    bit    m_live  = 1'b0;
    int    beats_taken = 0;

    always @(posedge clk) begin
        if (in_valid && a_in_ready) beats_taken++;
        if (rst) begin
            m_mode = 0; m_left = 0; m_total = 0; m_live = 1'b1;
        end else if (m_mode == 0) begin
            if (start) begin
                m_total = 0;
                if (len == 0) m_mode = 2;
                else begin m_left = int'(len); m_mode = 1; end
            end
        end else if (m_mode == 1) begin
            if (in_valid) begin
                m_total += longint'(in_sum);
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end else begin
            if (out_ready) m_mode = 0;
        end
    end

    function automatic logic [31:0] exp_data(input int w);
        return 32'(m_total % (longint'(1) << w));
    endfunction

    function automatic logic [31:0] exp_ovf(input int w);
        return {31'd0, m_total >= (longint'(1) << w)};
    endfunction

    // Single compare process: every cycle after reset, both instances.
    always @(negedge clk) begin
        if (m_live && !rst) begin
            chk("a_in_ready",  {31'd0, a_in_ready},  {31'd0, m_mode == 1});
            chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, m_mode == 2});
            chk("a_busy",      {31'd0, a_busy},      {31'd0, m_mode != 0});
            chk("a_out_data",  32'(a_out_data),      exp_data(WA));
            chk("a_overflow",  {31'd0, a_out_overflow}, exp_ovf(WA));
            chk("b_in_ready",  {31'd0, b_in_ready},  {31'd0, m_mode == 1});
            chk("b_out_valid", {31'd0, b_out_valid}, {31'd0, m_mode == 2});
            chk("b_busy",      {31'd0, b_busy},      {31'd0, m_mode != 0});
            chk("b_out_data",  32'(b_out_data),      exp_data(WB));
            chk("b_overflow",  {31'd0, b_out_overflow}, exp_ovf(WB));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change just after the falling edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [8:0] v);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_sum   = v;
        for (int i = 0; i < 20 && !done; i++) begin
            done = a_in_ready;
            step();
        end
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: in_ready never seen for beat 0x%0h", v);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = a_out_valid;
            step();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: out_valid got 0 expected 1");
        end
        out_ready = 1'b0;
    endtask

    task automatic pin_result(input string tag, input logic [31:0] ad, input logic ao,
                              input logic [31:0] bd, input logic bo);
        chk({tag, "_a_valid"}, {31'd0, a_out_valid}, 32'd1);
        chk({tag, "_a_data"},  32'(a_out_data), ad);
        chk({tag, "_a_ovf"},   {31'd0, a_out_overflow}, {31'd0, ao});
        chk({tag, "_b_data"},  32'(b_out_data), bd);
        chk({tag, "_b_ovf"},   {31'd0, b_out_overflow}, {31'd0, bo});
    endtask

    initial begin
        int beats_before;
        rst = 1'b1; start = 1'b0; len = '0;
        in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_in_ready",  {31'd0, a_in_ready},  32'd0);
        chk("reset_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("reset_busy",      {31'd0, a_busy},      32'd0);
        chk("reset_data",      32'(a_out_data),      32'd0);
        chk("reset_ovf",       {31'd0, a_out_overflow}, 32'd0);
        step();

        // Basic burst: 0xFF + 0x100 + 0x001 = 0x200
        do_start(3);
        send(9'h0FF); send(9'h100); send(9'h001);
        pin_result("basic", 32'h0200, 1'b0, 32'h0200, 1'b0);
        drain();
        step();

        // Overflow on the 10-bit instance: 3*0x1FF = 0x5FD
        do_start(3);
        send(9'h1FF); send(9'h1FF); send(9'h1FF);
        pin_result("ovf", 32'h05FD, 1'b0, 32'h01FD, 1'b1);
        drain();
        do_start(1);
        send(9'h001);
        pin_result("ovf_clear", 32'h0001, 1'b0, 32'h0001, 1'b0);
        drain();

        // Stalls on input, backpressure on output, start ignored while busy
        do_start(2);
        in_valid = 1'b1; in_sum = 9'h010; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_sum = 9'h020; step();
        in_valid = 1'b0;
        pin_result("stall", 32'h0030, 1'b0, 32'h0030, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 3);
            len   = 4'd3;
            step();
            chk("hold_data", 32'(a_out_data), 32'h0030);
            chk("hold_busy", {31'd0, a_busy}, 32'd1);
        end
        start = 1'b0;
        drain();
        step();
        chk("no_queued_start", {31'd0, a_busy}, 32'd0);

        // Zero-length burst
        do_start(0);
        chk("zero_in_ready", {31'd0, a_in_ready}, 32'd0);
        pin_result("zero", 32'h0, 1'b0, 32'h0, 1'b0);
        drain();

        // Maximum length: 15*0x1FF = 7665 = 0x1DF1 (0x1F1 mod 1024)
        beats_before = beats_taken;
        do_start(15);
        for (int i = 0; i < 15; i++) send(9'h1FF);
        pin_result("max", 32'h1DF1, 1'b0, 32'h01F1, 1'b1);
        in_valid = 1'b1; in_sum = 9'h1FF;
        drain();
        in_valid = 1'b0;
        chk("max_beats", 32'(beats_taken - beats_before), 32'd15);

        // Reset in the middle of a burst
        do_start(4);
        send(9'h011); send(9'h022);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_in_ready",  {31'd0, a_in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, a_busy},      32'd0);
        chk("rst_data",      32'(a_out_data),      32'd0);
        chk("rst_ovf",       {31'd0, a_out_overflow}, 32'd0);
        step(); step();
        chk("rst_no_result", {31'd0, a_out_valid}, 32'd0);
        do_start(1);
        send(9'h005);
        pin_result("after_rst", 32'h0005, 1'b0, 32'h0005, 1'b0);
        drain();
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
